pipelined_bk_adder: RTL and testbench

PIPELINED_BK_ADDER -- requirements
Module: pipelined_bk_adder

---
 rtl/bk_pkg.sv | 28 ++
 rtl/bk_cell.sv | 14 +
 rtl/pipelined_bk_adder.sv | 156 +++++++++++++++
 tb/tb_pipelined_bk_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and prefix operators for the pipelined Brent-Kung adder.
// A gray cell yields only a group generate; its propagate is forced to 0.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int unsigned LEVELS(input int unsigned width);
        return $clog2(width);
    endfunction

    function automatic pg_t bk_black(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic pg_t bk_gray(input pg_t hi, input pg_t lo);
        pg_t r;
        r   = bk_black(hi, lo);
        r.p = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bk_cell.sv
// One prefix-tree node: (g,p) o (g0,p0), black or gray by parameter.
module bk_cell
    import bk_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  pg_t i_hi,
    input  pg_t i_lo,
    output pg_t o_pg
);

    assign o_pg = GRAY ? bk_gray(i_hi, i_lo) : bk_black(i_hi, i_lo);

endmodule

// File: rtl/pipelined_bk_adder.sv
// Three-stage Brent-Kung adder/subtractor with valid/ready flow control.
// S1: generate/propagate, S2: prefix up-sweep, S3: down-sweep, sum and flags.
module pipelined_bk_adder
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int L = int'(LEVELS(WIDTH));

    logic             w_adv;
    logic             w_sub;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_b;
    pg_t  [WIDTH-1:0] w_pg_in;
    pg_t  [WIDTH-1:0] w_up0;
    pg_t  [WIDTH-1:0] w_up_out;
    pg_t  [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_p1;
    logic [WIDTH-1:0] w_g_pre;
    logic [WIDTH-1:0] w_unused_pre_p;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;

    logic             r1_v, r2_v, r3_v;
    logic             r1_cin, r2_cin;
    pg_t  [WIDTH-1:0] r1_pg;
    pg_t  [WIDTH-1:0] r2_pg;
    logic [WIDTH-1:0] r2_p;
    logic [WIDTH-1:0] r3_sum;
    logic             r3_cout, r3_ovf, r3_zero;

    assign w_adv     = !r3_v || out_ready;
    assign in_ready  = w_adv;
    assign w_sub     = SUB_EN && sub;
    assign w_b       = w_sub ? ~b : b;
    assign w_cin_eff = w_sub ? 1'b1 : cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_pg_in[i].g      = a[i] & w_b[i];
        assign w_pg_in[i].p      = a[i] ^ w_b[i];
        assign w_p1[i]           = r1_pg[i].p;
        assign w_g_pre[i]        = w_pre[i].g;
        assign w_unused_pre_p[i] = w_pre[i].p;
        if (i > 0) begin : g_fwd
            assign w_up0[i] = r1_pg[i];
        end
    end

    // Carry-in folded into bit 0, so every prefix below already includes it.
    bk_cell #(.GRAY(1'b1)) u_cin_cell (
        .i_hi (r1_pg[0]),
        .i_lo ({r1_cin, 1'b0}),
        .o_pg (w_up0[0])
    );

    for (genvar l = 0; l < L; l++) begin : g_up
        pg_t [WIDTH-1:0] w_in, w_out;
        if (l == 0) begin : g_src
            assign w_in = w_up0;
        end else begin : g_src
            assign w_in = g_up[l-1].w_out;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_cell
                bk_cell #(.GRAY((i + 1) == (2 ** (l + 1)))) u_cell (
                    .i_hi (w_in[i]),
                    .i_lo (w_in[i - (2 ** l)]),
                    .o_pg (w_out[i])
                );
            end else begin : g_pass
                assign w_out[i] = w_in[i];
            end
        end
    end
    assign w_up_out = g_up[L-1].w_out;

    // Down-sweep: every lower operand is already a full prefix, hence gray.
    for (genvar k = 0; k < L - 1; k++) begin : g_dn
        localparam int D = 2 ** (L - 2 - k);
        pg_t [WIDTH-1:0] w_in, w_out;
        if (k == 0) begin : g_src
            assign w_in = r2_pg;
        end else begin : g_src
            assign w_in = g_dn[k-1].w_out;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if ((i + 1) > D && ((i + 1) % (2 * D)) == D) begin : g_cell
                bk_cell #(.GRAY(1'b1)) u_cell (
                    .i_hi (w_in[i]),
                    .i_lo (w_in[i - D]),
                    .o_pg (w_out[i])
                );
            end else begin : g_pass
                assign w_out[i] = w_in[i];
            end
        end
    end
    assign w_pre = g_dn[L-2].w_out;

    assign w_c   = {w_g_pre[WIDTH-2:0], r2_cin};
    assign w_sum = r2_p ^ w_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v    <= 1'b0;
            r2_v    <= 1'b0;
            r3_v    <= 1'b0;
            r1_cin  <= 1'b0;
            r2_cin  <= 1'b0;
            r1_pg   <= '0;
            r2_pg   <= '0;
            r2_p    <= '0;
            r3_sum  <= '0;
            r3_cout <= 1'b0;
            r3_ovf  <= 1'b0;
            r3_zero <= 1'b0;
        end else if (w_adv) begin
            r1_v    <= in_valid;
            r1_pg   <= w_pg_in;
            r1_cin  <= w_cin_eff;
            r2_v    <= r1_v;
            r2_pg   <= w_up_out;
            r2_p    <= w_p1;
            r2_cin  <= r1_cin;
            r3_v    <= r2_v;
            r3_sum  <= w_sum;
            r3_cout <= w_g_pre[WIDTH-1];
            r3_ovf  <= w_c[WIDTH-1] ^ w_g_pre[WIDTH-1];
            r3_zero <= ~|w_sum;
        end
    end

    assign out_valid = r3_v;
    assign sum       = r3_sum;
    assign cout      = r3_cout;
    assign ovf       = r3_ovf;
    assign zero      = r3_zero;

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// Bench for pipelined_bk_adder: 16-bit add/sub instance plus a 64-bit SUB_EN=0 instance,
// both checked against an arithmetic reference model.
module tb_pipelined_bk_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
        string       name;
    } vec_t;

    typedef struct {
        res_t        r;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, sum;

    logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf, n_zero;
    logic [63:0] n_a, n_b, n_sum;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_out, first_out, last_out;
    bit          chk_lat, hold_pending, saw_stall, last_acc;
    res_t        held;
    string       tag;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    pipelined_bk_adder #(.WIDTH(16), .SUB_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_bk_adder #(.WIDTH(64), .SUB_EN(1'b0)) dut_nosub (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .sum(n_sum), .cout(n_cout), .ovf(n_ovf), .zero(n_zero)
    );

    function automatic res_t mk(input logic [63:0] s, input bit c, input bit o, input bit z);
        return '{sum: s, cout: c, ovf: o, zero: z};
    endfunction

    // Reference: plain unsigned/signed arithmetic at width w.
    function automatic res_t model(input int unsigned w, input bit sub_en,
                                   input logic [63:0] ai, input logic [63:0] bi,
                                   input bit ci, input bit si);
        res_t               r;
        logic [63:0]        mask, ua, ub;
        logic [65:0]        full;
        logic signed [67:0] sa, sb, sr, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = ai & mask;
        ub   = bi & mask;
        sa   = $signed({4'b0, ua}) - (ua[w-1] ? $signed(68'd1 << w) : 68'sd0);
        sb   = $signed({4'b0, ub}) - (ub[w-1] ? $signed(68'd1 << w) : 68'sd0);
        lim  = $signed(68'd1 << (w - 1));
        if (si && sub_en) begin
            r.sum  = (ua - ub) & mask;
            r.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            full   = {2'b0, ua} + {2'b0, ub} + {65'b0, ci};
            r.sum  = full[63:0] & mask;
            r.cout = full[w];
            sr     = sa + sb;
            if (ci) sr = sr + 68'sd1;
        end
        r.ovf  = (sr >= lim) || (sr < -lim);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic res_t res16();
        return '{sum: {48'b0, sum}, cout: cout, ovf: ovf, zero: zero};
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock of the 16-bit DUT: drive at negedge, sample 1ns later.
    task automatic cycle(input bit v, input logic [15:0] ai, input logic [15:0] bi,
                         input bit ci, input bit si, input bit ordy,
                         input bit use_exp = 1'b0, input res_t ex = '0);
        @(negedge clk);
        in_valid  = v;
        a         = ai;
        b         = bi;
        cin       = ci;
        sub       = si;
        out_ready = ordy;
        cyc++;
        #1;
        if (hold_pending) check({tag, "_hold"}, res16(), held);
        hold_pending = out_valid && !out_ready;
        held         = res16();
        if (out_valid && out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_spurious: got result %h, required no result", tag, res16());
            end else begin
                e = exp_q.pop_front();
                check({tag, "_result"}, res16(), e.r);
                if (chk_lat) check({tag, "_latency"}, 67'(cyc - e.cyc), 67'd3);
            end
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        if (in_valid && !in_ready) saw_stall = 1'b1;
        last_acc = in_valid && in_ready;
        if (last_acc)
            exp_q.push_back('{r: (use_exp ? ex : model(16, 1'b1, {48'b0, ai}, {48'b0, bi}, ci, si)), cyc: cyc});
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        check({tag, "_drained"}, 67'(exp_q.size()), 67'd0);
    endtask

    task automatic beat64(input logic [63:0] ai, input logic [63:0] bi, input bit ci,
                          input bit si, input res_t ex, input string nm);
        int lat;
        @(negedge clk);
        n_in_valid = 1'b1;
        n_a = ai;
        n_b = bi;
        n_cin = ci;
        n_sub = si;
        @(negedge clk);
        n_in_valid = 1'b0;
        lat = 1;
        while (!n_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 67'(lat), 67'd3);
        check(nm, {n_sum, n_cout, n_ovf, n_zero}, ex);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[8];
        logic [15:0] ba[4], bb[4];
        bit          bc[4], bs[4];
        int          idx;
        logic [63:0] ra, rb;
        bit          rc, rs;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(64'h0000, 1, 0, 1), "ffff_plus_1"};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(64'h8000, 0, 1, 0), "pos_ovf_add"};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, mk(64'h7FFF, 1, 1, 0), "neg_ovf_sub"};
        vt[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, mk(64'h0000, 0, 0, 1), "zero_plus_zero"};
        vt[4] = '{16'h0005, 16'h0005, 1'b0, 1'b1, mk(64'h0000, 1, 0, 1), "five_minus_five"};
        vt[5] = '{16'h0003, 16'h0005, 1'b1, 1'b1, mk(64'hFFFE, 0, 0, 0), "borrow_sub"};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, mk(64'h0000, 1, 1, 1), "min_plus_min"};
        vt[7] = '{16'h1234, 16'h1111, 1'b1, 1'b0, mk(64'h2346, 0, 0, 0), "add_with_cin"};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b1;
        n_out = 0; first_out = 0; last_out = 0;
        chk_lat = 1'b1; hold_pending = 1'b0; saw_stall = 1'b0; last_acc = 1'b0;
        held = '0;
        tag = "reset";

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 67'(out_valid), 67'd0);
        check("reset_outputs", res16(), 67'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 67'(in_ready), 67'd1);

        foreach (vt[i]) begin
            tag = vt[i].name;
            cycle(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1, 1'b1, vt[i].exp);
            drain();
        end

        tag = "random";
        n_out = 0;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        drain();
        check("random_count", 67'(n_out), 67'd100);
        check("random_one_per_cycle", 67'(last_out - first_out), 67'd99);

        tag = "backpressure";
        chk_lat = 1'b0;
        n_out = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ba[i] = 16'($urandom); bb[i] = 16'($urandom); bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(idx < 4, ba[idx % 4], bb[idx % 4], bc[idx % 4], bs[idx % 4], 1'b0);
            if (last_acc) idx++;
        end
        for (int i = 0; i < 10 && idx < 4; i++) begin
            cycle(1'b1, ba[idx], bb[idx], bc[idx], bs[idx], 1'b1);
            if (last_acc) idx++;
        end
        drain();
        check("backpressure_in_ready_fell", 67'(saw_stall), 67'd1);
        check("backpressure_count", 67'(n_out), 67'd4);

        tag = "midreset";
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("midreset_pipe_full", 67'(out_valid), 67'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_valid_drops", 67'(out_valid), 67'd0);
        check("midreset_outputs", res16(), 67'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_out = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            check("midreset_no_stale", 67'(out_valid), 67'd0);
        end
        chk_lat = 1'b1;
        cycle(1'b1, 16'h00A5, 16'h005A, 1'b1, 1'b0, 1'b1, 1'b1, mk(64'h0100, 0, 0, 0));
        drain();
        check("midreset_next_beat", 67'(n_out), 67'd1);

        beat64(64'd5, 64'd3, 1'b0, 1'b1, mk(64'd8, 0, 0, 0), "nosub_5_3");
        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            rs = 1'($urandom);
            beat64(ra, rb, rc, rs, model(64, 1'b0, ra, rb, rc, rs), "nosub_w64_random");
        end
        beat64('1, 64'd0, 1'b1, 1'b1, model(64, 1'b0, '1, 64'd0, 1'b1, 1'b1), "nosub_w64_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
